// File: rtl/dmem_resp.sv
// Data-memory responder: turns one memrd/memwr request into a single req/ack
// transaction on a variable-latency memory port, stalling the pipeline meanwhile.
module dmem_resp #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              memrd,
  input  logic              memwr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic [1:0]        err_code,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic [1:0]          err_code_q, err_code_d;

  logic req_present;
  logic bad_req;
  logic timeout_hit;

  assign req_present = memrd | memwr;
  assign bad_req     = (memrd & memwr) | addr[0];
  // Counter holds the number of completed ISSUE cycles, so this is the last allowed one.
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_present) begin
          state_d = bad_req ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall = ((state_q == IDLE) && req_present) || (state_q == ISSUE);
  end

  always_comb begin
    cnt_d       = cnt_q;
    mem_req_d   = (state_d == ISSUE);
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    rvalid_d    = 1'b0;
    err_d       = 1'b0;
    err_code_d  = 2'b00;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req_present) begin
          if (memrd && memwr) begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
          end else if (addr[0]) begin
            err_d      = 1'b1;
            err_code_d = 2'b01;
          end else begin
            mem_we_d    = memwr;
            mem_addr_d  = addr;
            mem_wdata_d = wdata;
          end
        end
      end
      ISSUE: begin
        if (cnt_q != CNT_W'(TIMEOUT)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Ack takes priority over a timeout landing in the same cycle.
        if (mem_ack) begin
          if (!mem_we_q) begin
            rdata_d  = mem_rdata;
            rvalid_d = 1'b1;
          end
        end else if (timeout_hit) begin
          err_d      = 1'b1;
          err_code_d = 2'b10;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      cnt_q       <= cnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: directed and randomized transactions
// compared against a transaction-level model of the responder's rules.
module tb_dmem_resp;

  localparam int T = 15;

  logic        clk;
  logic        rst_n;
  logic        memrd, memwr;
  logic [15:0] addr, wdata;
  logic        stall;
  logic [15:0] rdata;
  logic        rvalid, err;
  logic [1:0]  err_code;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;

  int errors = 0;
  int checks = 0;
  logic [15:0] rdata_model = 16'h0000;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] wd;
    int          lat;
    logic [15:0] rdat;
    string       name;
  } txn_t;

  dmem_resp #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(T)) dut (
    .clk(clk), .rst_n(rst_n), .memrd(memrd), .memwr(memwr), .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rvalid(rvalid), .err(err), .err_code(err_code),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome of one request: stalled cycles, request cycles and the response pulse.
  function automatic void model(input logic rd, input logic wr, input logic [15:0] a, input int lat,
                                output int e_st, output int e_rq, output logic e_rv,
                                output logic e_er, output logic [1:0] e_ec);
    e_rv = 1'b0; e_er = 1'b0; e_ec = 2'b00;
    if (rd && wr) begin
      e_st = 1; e_rq = 0; e_er = 1'b1; e_ec = 2'b11;
    end else if (a % 2 == 1) begin
      e_st = 1; e_rq = 0; e_er = 1'b1; e_ec = 2'b01;
    end else if (lat > T) begin
      e_st = 1 + T; e_rq = T; e_er = 1'b1; e_ec = 2'b10;
    end else begin
      e_st = 1 + lat; e_rq = lat; e_rv = rd;
    end
  endfunction

  // Pipeline-side driver: holds the request until stall falls, memory acks on the lat-th req cycle.
  task automatic run_txn(input txn_t t, output int st_n, output int rq_n, output logic rv,
                         output logic er, output logic [1:0] ec, output logic [15:0] rdo,
                         output logic ok);
    bit done;
    st_n = 0; rq_n = 0; rv = 1'b0; er = 1'b0; ec = 2'b00; rdo = 16'h0; ok = 1'b1; done = 0;
    @(negedge clk);
    memrd = t.rd; memwr = t.wr; addr = t.a; wdata = t.wd; mem_ack = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      #1;
      if (stall) begin
        st_n++;
        if (rvalid || err) ok = 1'b0;
        if (mem_req) begin
          rq_n++;
          if (mem_addr !== t.a || mem_we !== t.wr || mem_wdata !== t.wd) ok = 1'b0;
        end
        mem_ack   = mem_req && (rq_n == t.lat);
        mem_rdata = mem_ack ? t.rdat : 16'($urandom);
        @(negedge clk);
      end else begin
        rv = rvalid; er = err; ec = err_code; rdo = rdata;
        if (mem_req) ok = 1'b0;
        done = 1;
      end
    end
    @(posedge clk);
    #1;
    memrd = 1'b0; memwr = 1'b0; mem_ack = 1'b0;
    #1;
    if (mem_req || stall || rvalid || err) ok = 1'b0;
    $display("txn %s rd=%0b wr=%0b addr=%h lat=%0d stall=%0d req=%0d rv=%0b err=%0b code=%b rdata=%h ok=%0b",
             t.name, t.rd, t.wr, t.a, t.lat, st_n, rq_n, rv, er, ec, rdo, ok);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; memrd = 1'b0; memwr = 1'b0; addr = 16'h0; wdata = 16'h0;
    mem_rdata = 16'h0; mem_ack = 1'b0;
    #12;
    checks++;
    if ({mem_req, mem_we, rvalid, err, err_code, stall} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=0000000", {mem_req, mem_we, rvalid, err, err_code, stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, rdata} !== 48'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {mem_addr, mem_wdata, rdata});
    end
    memrd = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall_comb got=%b want=1", stall);
    end
    memrd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rdata_model = 16'h0000;
  endtask

  task automatic test_directed();
    txn_t tv[6];
    int st, rq, e_st, e_rq;
    logic rv, er, ok, e_rv, e_er;
    logic [1:0] ec, e_ec;
    logic [15:0] rdo;
    tv[0] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1,   16'hBEEF, "read_fast"};
    tv[1] = '{1'b0, 1'b1, 16'h0020, 16'h1234, 4,   16'h0000, "write_wait3"};
    tv[2] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 100, 16'h5555, "read_timeout"};
    tv[3] = '{1'b1, 1'b0, 16'h0013, 16'h0000, 1,   16'h6666, "misaligned"};
    tv[4] = '{1'b1, 1'b1, 16'h0040, 16'h7777, 1,   16'h8888, "conflict"};
    tv[5] = '{1'b1, 1'b0, 16'h0050, 16'h0000, T,   16'hA5A5, "ack_at_timeout"};
    foreach (tv[i]) begin
      run_txn(tv[i], st, rq, rv, er, ec, rdo, ok);
      model(tv[i].rd, tv[i].wr, tv[i].a, tv[i].lat, e_st, e_rq, e_rv, e_er, e_ec);
      if (e_rv) rdata_model = tv[i].rdat;
      checks++; if (st !== e_st) begin errors++; $display("FAIL %s stall_cycles got=%0d want=%0d", tv[i].name, st, e_st); end
      checks++; if (rq !== e_rq) begin errors++; $display("FAIL %s req_cycles got=%0d want=%0d", tv[i].name, rq, e_rq); end
      checks++; if ({rv, er, ec} !== {e_rv, e_er, e_ec}) begin errors++; $display("FAIL %s resp rv/err/code got=%b want=%b", tv[i].name, {rv, er, ec}, {e_rv, e_er, e_ec}); end
      checks++; if (rdo !== rdata_model) begin errors++; $display("FAIL %s rdata got=%h want=%h", tv[i].name, rdo, rdata_model); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s hold_and_pulse got=%b want=1", tv[i].name, ok); end
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    memrd = 1'b1; addr = 16'h0060; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL midrst_req_before got=%b want=1", mem_req); end
    rst_n = 1'b0;
    memrd = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, rvalid, err, err_code, stall} !== 7'b0 || {mem_addr, mem_wdata, rdata} !== 48'h0) begin
      errors++;
      $display("FAIL midrst_outputs got=%b/%h want=0", {mem_req, mem_we, rvalid, err, err_code, stall}, {mem_addr, mem_wdata, rdata});
    end
    rdata_model = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, rvalid, err, stall} !== 4'b0 || rdata !== 16'h0000) begin
        errors++;
        $display("FAIL stray_ack cyc=%0d got=%b rdata=%h want=0000 rdata=0000", k, {mem_req, rvalid, err, stall}, rdata);
      end
    end
    mem_ack = 1'b0;
    $display("txn mid_reset_stray_ack done");
  endtask

  task automatic test_back_to_back();
    txn_t tv[2];
    int st, rq, e_st, e_rq;
    logic rv, er, ok, e_rv, e_er;
    logic [1:0] ec, e_ec;
    logic [15:0] rdo;
    tv[0] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 2, 16'hCAFE, "b2b_read"};
    tv[1] = '{1'b0, 1'b1, 16'h0102, 16'h4321, 1, 16'h0000, "b2b_write"};
    foreach (tv[i]) begin
      run_txn(tv[i], st, rq, rv, er, ec, rdo, ok);
      model(tv[i].rd, tv[i].wr, tv[i].a, tv[i].lat, e_st, e_rq, e_rv, e_er, e_ec);
      if (e_rv) rdata_model = tv[i].rdat;
      checks++; if (st !== e_st || rq !== e_rq) begin errors++; $display("FAIL %s stall/req got=%0d/%0d want=%0d/%0d", tv[i].name, st, rq, e_st, e_rq); end
      checks++; if ({rv, er, ec} !== {e_rv, e_er, e_ec} || rdo !== rdata_model) begin errors++; $display("FAIL %s resp got=%b/%h want=%b/%h", tv[i].name, {rv, er, ec}, rdo, {e_rv, e_er, e_ec}, rdata_model); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL %s no_double_issue got=%b want=1", tv[i].name, ok); end
    end
  endtask

  task automatic test_random();
    txn_t t;
    int st, rq, e_st, e_rq, kind;
    logic rv, er, ok, e_rv, e_er;
    logic [1:0] ec, e_ec;
    logic [15:0] rdo;
    for (int n = 0; n < 25; n++) begin
      kind   = $urandom_range(0, 9);
      t.rd   = ($urandom_range(0, 1) == 1);
      t.wr   = !t.rd;
      t.a    = 16'($urandom) & 16'hFFFE;
      t.wd   = 16'($urandom);
      t.lat  = $urandom_range(1, T + 3);
      t.rdat = 16'($urandom);
      t.name = "random";
      if (kind == 0) begin t.rd = 1'b1; t.wr = 1'b1; end
      if (kind == 1) t.a = t.a | 16'h0001;
      run_txn(t, st, rq, rv, er, ec, rdo, ok);
      model(t.rd, t.wr, t.a, t.lat, e_st, e_rq, e_rv, e_er, e_ec);
      if (e_rv) rdata_model = t.rdat;
      checks++; if (st !== e_st || rq !== e_rq) begin errors++; $display("FAIL random%0d stall/req got=%0d/%0d want=%0d/%0d", n, st, rq, e_st, e_rq); end
      checks++; if ({rv, er, ec} !== {e_rv, e_er, e_ec}) begin errors++; $display("FAIL random%0d resp got=%b want=%b", n, {rv, er, ec}, {e_rv, e_er, e_ec}); end
      checks++; if (rdo !== rdata_model) begin errors++; $display("FAIL random%0d rdata got=%h want=%h", n, rdo, rdata_model); end
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL random%0d hold_and_pulse got=%b want=1", n, ok); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
# dmem_resp

Data-memory responder for the CPU memory stage. It services the load/store/PUSH/POP requests raised by the control decoder's `memrd`/`memwr` strobes and converts each one into a single registered transaction on an external variable-latency memory port (`req`/`ack`). While a transaction is outstanding it stalls the pipeline. It returns load data to the writeback path and flags misaligned, conflicting and timed-out accesses.

## Interface
Parameters:
- `ADDR_W`, 16: byte-address width
- `DATA_W`, 16: data word width; word accesses only
- `TIMEOUT`, 15: maximum cycles in ISSUE without `mem_ack` before abort; must be ≥1

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  async active-low reset
- `memrd`  in  1  load/POP request from control decode
- `memwr`  in  1  store/PUSH request from control decode
- `addr`  in  ADDR_W  byte address (ALU result or SP)
- `wdata`  in  DATA_W  store data
- `stall`  out  1  hold pipeline (combinational)
- `rdata`  out  DATA_W  last load data, registered
- `rvalid`  out  1  one-cycle pulse: `rdata` updated this cycle
- `err`  out  1  one-cycle pulse: access failed
- `err_code`  out  2  01 misaligned, 10 timeout, 11 rd/wr conflict; 00 when `err`=0
- `mem_req`  out  1  memory request, registered
- `mem_we`  out  1  1=write, valid with `mem_req`
- `mem_addr`  out  ADDR_W  latched address
- `mem_wdata`  out  DATA_W  latched store data
- `mem_rdata`  in  DATA_W  read data, valid with `mem_ack`
- `mem_ack`  in  1  completion strobe from memory

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE, request present (`memrd|memwr`):
  - If `memrd&memwr`: go to RESP with error 11. No memory access.
  - Else if `addr[0]`=1: go to RESP with error 01. No memory access.
  - Else: latch `addr`, `wdata` and `mem_we=memwr`, then go to ISSUE.
- ISSUE:
  - `mem_req`=1. `mem_addr`/`mem_we`/`mem_wdata` are held stable.
  - Timeout counter increments each cycle.
  - On `mem_ack`: if read, capture `mem_rdata` into `rdata`. Go to RESP.
  - If the counter reaches TIMEOUT without ack: abort with error 10. `rdata` unchanged. Go to RESP.
- RESP: one cycle, then IDLE unconditionally.
  - `rvalid`=1 only for a successful read.
  - `err`/`err_code` are driven only here.
  - `mem_req`=0.
- `stall` = (IDLE & (`memrd|memwr`)) | ISSUE. It is low in RESP, so the stalled instruction retires at the end of RESP. The next instruction's request is sampled in the following IDLE cycle, so there is no double issue.
- `mem_ack` outside ISSUE is ignored.
- `mem_ack` in the same cycle the counter reaches TIMEOUT counts as success; ack wins.
- Timeout counter width is clog2(TIMEOUT+1). It is cleared on entry to ISSUE and saturates; no wrap.

## Timing
- Reset (async assert, any state): state=IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `rdata`=0, `rvalid`=0, `err`=0, `err_code`=00, counter=0.
  - `stall` follows the combinational rule, so it is high in reset only if a request is present.
  - Reset mid-ISSUE drops `mem_req` immediately. A later `mem_ack` is ignored.
- Cycle 0: request seen in IDLE, `stall`=1.
- Cycle 1: `mem_req`=1. Earliest ack is in cycle 1.
- Cycle 2: RESP, `rvalid`/`err` pulse, `stall`=0.
- Minimum occupancy is 3 cycles per access (2 stalled). Each extra memory wait cycle adds 1.
- Error paths (01/11): cycle 0 IDLE, cycle 1 RESP. Total 2 cycles, `mem_req` never asserted.
- Timeout: RESP is entered the cycle after the TIMEOUT-th ISSUE cycle without ack. `mem_req` is high for exactly TIMEOUT cycles.
- `rdata` changes only on the edge that captures `mem_ack` for a read. It is stable otherwise, including across writes and errors.

## Test plan
- Read, ack in same cycle as `mem_req`, `addr`=0x0010, `mem_rdata`=0xBEEF:
  - `stall` high for 2 cycles.
  - `mem_req` for 1 cycle with `mem_we`=0, `mem_addr`=0x0010.
  - Next cycle `rvalid`=1, `rdata`=0xBEEF, `stall`=0.
- Write, `addr`=0x0020, `wdata`=0x1234, ack after 3 wait cycles:
  - `mem_req` held 4 cycles, `mem_we`=1, `mem_wdata`=0x1234 stable throughout.
  - `rvalid` never asserts; `rdata` unchanged.
- Read with no ack, TIMEOUT=15:
  - `mem_req` high exactly 15 cycles.
  - Then `err`=1, `err_code`=10 for one cycle, `stall` drops, `rdata` keeps its old value.
- Error cases without memory access:
  - `memrd`=1 with `addr`=0x0013: `err_code`=01 in cycle 1.
  - `memrd`=`memwr`=1: `err_code`=11.
  - In both cases `mem_req` stays 0 and `stall` lasts 1 cycle.
- Mid-access reset and stray ack:
  - Assert `rst_n`=0 in the 2nd ISSUE cycle: `mem_req` drops asynchronously and all outputs return to reset values.
  - After release, a stray `mem_ack` produces no `rvalid`/`err`.
- Back-to-back read then write (pipeline holds each request until `stall` falls):
  - Exactly two `mem_req` transactions with no duplicate issue.
  - Second request is sampled in the IDLE cycle after the first RESP.
